// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: serial JTAG link between the bench-side driver and the TAP responder
interface jtag_tap_ctrl_if;
    logic tdi;
    logic tms;
    logic tdo;
    logic tdo_en;
    modport master (output tdi, tms, input tdo, tdo_en);
    modport slave (input tdi, tms, output tdo, tdo_en);
endinterface

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: 1149.1-style TAP responder with IR, BYPASS, IDCODE and a parallel USER register
module jtag_tap_ctrl #(
    parameter int IR_WIDTH = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1A5B_C0DF,
    parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = 4'b0001,
    parameter logic [IR_WIDTH-1:0] INSTR_USER = 4'b0010,
    parameter int USER_WIDTH = 8
) (
    input  logic                  tck,
    input  logic                  trst,
    jtag_tap_ctrl_if.slave        jtag,
    output logic [IR_WIDTH-1:0]   ir_out,
    output logic [3:0]            tap_state,
    input  logic [USER_WIDTH-1:0] user_dr_in,
    output logic [USER_WIDTH-1:0] user_dr_out,
    output logic                  user_update
);
    localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SEL_DR = 4'd2, CAP_DR = 4'd3,
                           SH_DR = 4'd4, EX1_DR = 4'd5, PA_DR = 4'd6, EX2_DR = 4'd7,
                           UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11,
                           EX1_IR = 4'd12, PA_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15;
    logic tms, tdi, tdo_q, tdo_en_q, bypass, dr_lsb;
    logic sel_id, sel_user, sel_byp;
    logic [3:0] nxt;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [31:0] id_sr;
    logic [USER_WIDTH-1:0] user_sr;
    assign tms = jtag.tms;
    assign tdi = jtag.tdi;
    assign jtag.tdo = tdo_q;
    assign jtag.tdo_en = tdo_en_q;
    assign sel_id = ir_out == INSTR_IDCODE;
    assign sel_user = ir_out == INSTR_USER;
    assign sel_byp = !sel_id && !sel_user;
    assign dr_lsb = sel_id ? id_sr[0] : sel_user ? user_sr[0] : bypass;
    always_comb begin
        nxt = TLR;
        case (tap_state)
            TLR:                 nxt = tms ? TLR : RTI;
            RTI, UPD_DR, UPD_IR: nxt = tms ? SEL_DR : RTI;
            SEL_DR:              nxt = tms ? SEL_IR : CAP_DR;
            SEL_IR:              nxt = tms ? TLR : CAP_IR;
            CAP_DR, SH_DR:       nxt = tms ? EX1_DR : SH_DR;
            EX1_DR:              nxt = tms ? UPD_DR : PA_DR;
            PA_DR:               nxt = tms ? EX2_DR : PA_DR;
            EX2_DR:              nxt = tms ? UPD_DR : SH_DR;
            CAP_IR, SH_IR:       nxt = tms ? EX1_IR : SH_IR;
            EX1_IR:              nxt = tms ? UPD_IR : PA_IR;
            PA_IR:               nxt = tms ? EX2_IR : PA_IR;
            EX2_IR:              nxt = tms ? UPD_IR : SH_IR;
            default:             nxt = TLR;
        endcase
    end
    always_ff @(posedge tck) begin
        if (trst) begin
            tap_state <= TLR;
            ir_out <= INSTR_IDCODE;
            ir_sr <= '0;
            id_sr <= '0;
            user_sr <= '0;
            bypass <= 1'b0;
            user_dr_out <= '0;
            user_update <= 1'b0;
        end else begin
            tap_state <= nxt;
            user_update <= tap_state == UPD_DR && sel_user;
            // entering TLR resets the instruction together with the state
            if (nxt == TLR) ir_out <= INSTR_IDCODE;
            else if (tap_state == UPD_IR) ir_out <= ir_sr;
            if (tap_state == CAP_IR) ir_sr <= IR_WIDTH'(1);
            else if (tap_state == SH_IR) ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
            if (sel_id && tap_state == CAP_DR) id_sr <= IDCODE_VAL;
            else if (sel_id && tap_state == SH_DR) id_sr <= {tdi, id_sr[31:1]};
            if (sel_user && tap_state == CAP_DR) user_sr <= user_dr_in;
            else if (sel_user && tap_state == SH_DR) user_sr <= {tdi, user_sr[USER_WIDTH-1:1]};
            if (sel_byp && tap_state == CAP_DR) bypass <= 1'b0;
            else if (sel_byp && tap_state == SH_DR) bypass <= tdi;
            if (sel_user && tap_state == UPD_DR) user_dr_out <= user_sr;
        end
    end
    // after a reset posedge the state is TLR, so the next negedge clears tdo/tdo_en
    always_ff @(negedge tck) begin
        tdo_en_q <= tap_state == SH_IR || tap_state == SH_DR;
        tdo_q <= tap_state == SH_IR ? ir_sr[0] : tap_state == SH_DR ? dr_lsb : 1'b0;
    end
endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: state-walk vector table plus a tdo scoreboard for the JTAG TAP responder
module tb_jtag_tap_ctrl;
    typedef struct {
        logic       tms;
        logic       tdi;
        logic [3:0] st;
    } walk_t;
    logic tck = 1'b0;
    logic trst = 1'b1;
    logic [3:0] ir_out, tap_state;
    logic [7:0] user_dr_in = 8'h00;
    logic [7:0] user_dr_out;
    logic user_update;
    int n_chk = 0;
    int n_pass = 0;
    bit mon_on = 1'b0;
    logic exp_q[$];
    walk_t walk[$];
    jtag_tap_ctrl_if jif();
    jtag_tap_ctrl dut (
        .tck(tck), .trst(trst), .jtag(jif), .ir_out(ir_out), .tap_state(tap_state),
        .user_dr_in(user_dr_in), .user_dr_out(user_dr_out), .user_update(user_update)
    );
    always #5 tck = ~tck;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask
    task automatic tick(input logic m, input logic d);
        jif.tms = m;
        jif.tdi = d;
        @(posedge tck);
        #1;
    endtask
    task automatic do_reset();
        trst = 1'b1;
        tick(0, 0);
        tick(0, 0);
        trst = 1'b0;
    endtask
    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask
    task automatic load_ir(input logic [3:0] v);
        tick(1, 0); tick(1, 0); tick(0, 0);
        push_bits(32'h1, 4);
        tick(0, 0);
        for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
        tick(1, 0); tick(0, 0);
    endtask
    task automatic scan_dr(input logic [31:0] d, input logic [31:0] e, input int n);
        tick(1, 0); tick(0, 0);
        push_bits(e, n);
        tick(0, 0);
        for (int i = 0; i < n; i++) tick(i == n - 1, d[i]);
    endtask
    task automatic drain(input string name);
        check({name, "_bits_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask
    function automatic walk_t mk(input logic m, input logic [3:0] s);
        walk_t w;
        w.tms = m;
        w.tdi = m ^ s[0];
        w.st = s;
        return w;
    endfunction
    // scoreboard: every negedge that raises tdo_en must produce the next expected bit
    always @(negedge tck) begin
        #1;
        if (mon_on && jif.tdo_en) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL tdo_extra: got bit %b with nothing expected at %0t", jif.tdo, $time);
            end else check("tdo", {31'b0, jif.tdo}, {31'b0, exp_q.pop_front()});
        end
    end
    initial begin
        jif.tms = 1'b0;
        jif.tdi = 1'b0;
        walk.push_back(mk(1, 0)); walk.push_back(mk(0, 1)); walk.push_back(mk(0, 1)); walk.push_back(mk(1, 2));
        walk.push_back(mk(0, 3)); walk.push_back(mk(1, 5)); walk.push_back(mk(0, 6)); walk.push_back(mk(0, 6));
        walk.push_back(mk(1, 7)); walk.push_back(mk(0, 4)); walk.push_back(mk(0, 4)); walk.push_back(mk(1, 5));
        walk.push_back(mk(1, 8)); walk.push_back(mk(1, 2)); walk.push_back(mk(1, 9)); walk.push_back(mk(0, 10));
        walk.push_back(mk(0, 11)); walk.push_back(mk(1, 12)); walk.push_back(mk(0, 13)); walk.push_back(mk(1, 14));
        walk.push_back(mk(1, 15)); walk.push_back(mk(0, 1)); walk.push_back(mk(1, 2)); walk.push_back(mk(1, 9));
        walk.push_back(mk(1, 0)); walk.push_back(mk(0, 1)); walk.push_back(mk(1, 2)); walk.push_back(mk(0, 3));
        walk.push_back(mk(0, 4)); walk.push_back(mk(1, 5)); walk.push_back(mk(0, 6)); walk.push_back(mk(1, 7));
        walk.push_back(mk(1, 8)); walk.push_back(mk(0, 1)); walk.push_back(mk(1, 2)); walk.push_back(mk(1, 9));
        walk.push_back(mk(0, 10)); walk.push_back(mk(1, 12)); walk.push_back(mk(1, 15)); walk.push_back(mk(1, 2));
        walk.push_back(mk(1, 9)); walk.push_back(mk(0, 10)); walk.push_back(mk(0, 11)); walk.push_back(mk(0, 11));
        walk.push_back(mk(1, 12)); walk.push_back(mk(0, 13)); walk.push_back(mk(0, 13)); walk.push_back(mk(1, 14));
        walk.push_back(mk(0, 11)); walk.push_back(mk(1, 12)); walk.push_back(mk(0, 13)); walk.push_back(mk(1, 14));
        walk.push_back(mk(1, 15)); walk.push_back(mk(0, 1));
        tick(0, 0);
        tick(0, 0);
        check("rst_state", tap_state, 0);
        check("rst_ir", ir_out, 4'b0001);
        check("rst_user_out", user_dr_out, 0);
        check("rst_user_upd", user_update, 0);
        @(negedge tck);
        #2;
        check("rst_tdo", jif.tdo, 0);
        check("rst_tdo_en", jif.tdo_en, 0);
        trst = 1'b0;
        foreach (walk[i]) begin
            tick(walk[i].tms, walk[i].tdi);
            check($sformatf("walk%0d", i), tap_state, walk[i].st);
        end
        jif.tms = 1'b0;
        #2 jif.tms = 1'b1;
        #3 jif.tms = 1'b0;
        @(posedge tck);
        #1;
        check("tms_glitch", tap_state, 1);
        do_reset();
        mon_on = 1'b1;
        tick(0, 0);
        scan_dr($urandom, 32'h1A5B_C0DF, 32);
        check("id_ex1", tap_state, 5);
        tick(1, 0);
        tick(0, 0);
        drain("idcode");
        check("id_tdo_en_off", jif.tdo_en, 0);
        do_reset();
        tick(0, 0);
        load_ir(4'b1111);
        check("ir_all_ones", ir_out, 4'b1111);
        scan_dr(32'b1101, 32'b1010, 4);
        tick(1, 0);
        tick(0, 0);
        check("byp_no_upd", user_dr_out, 0);
        drain("ir_bypass");
        do_reset();
        tick(0, 0);
        load_ir(4'b0010);
        check("ir_user", ir_out, 4'b0010);
        user_dr_in = 8'h3C;
        scan_dr(32'hA5, 32'h3C, 8);
        check("user_pre_upd", user_dr_out, 0);
        tick(1, 0);
        check("user_upd_state", tap_state, 8);
        check("user_upd_early", user_update, 0);
        tick(0, 0);
        check("user_out", user_dr_out, 8'hA5);
        check("user_upd_pulse", user_update, 1);
        tick(0, 0);
        check("user_upd_end", user_update, 0);
        drain("user");
        tick(1, 0);
        tick(0, 0);
        push_bits(32'h3C, 4);
        tick(0, 0);
        tick(0, 1);
        tick(0, 0);
        tick(0, 1);
        trst = 1'b1;
        tick(0, 0);
        check("trst_state", tap_state, 0);
        check("trst_user_out", user_dr_out, 0);
        check("trst_ir", ir_out, 4'b0001);
        check("trst_no_upd", user_update, 0);
        @(negedge tck);
        #2;
        check("trst_tdo_en", jif.tdo_en, 0);
        check("trst_tdo", jif.tdo, 0);
        tick(0, 0);
        check("trst_no_upd2", user_update, 0);
        trst = 1'b0;
        drain("trst");
        mon_on = 1'b0;
        do_reset();
        tick(0, 0);
        load_ir(4'b0010);
        exp_q.delete();
        tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 0);
        check("park_sh_dr", tap_state, 4);
        for (int i = 0; i < 5; i++) tick(1, 0);
        check("park_dr_state", tap_state, 0);
        check("park_dr_ir", ir_out, 4'b0001);
        tick(0, 0);
        load_ir(4'b0010);
        exp_q.delete();
        check("park_ir_user", ir_out, 4'b0010);
        tick(1, 0); tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        check("park_pa_ir", tap_state, 13);
        for (int i = 0; i < 5; i++) tick(1, 0);
        check("park_ir_state", tap_state, 0);
        check("park_ir_ir", ir_out, 4'b0001);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
